afh_map_builder: RTL and testbench



---
 rtl/afh_pkg.sv | 27 ++
 rtl/afh_map_ram.sv | 29 ++
 rtl/afh_map_builder.sv | 142 ++++++++++++++
 tb/tb_afh_map_builder.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/afh_pkg.sv
// Shared constants, FSM state type and basic-hop-index to RF-channel mapping for the AFH map builder.
package afh_pkg;

    localparam int         NUM_CH  = 79;
    localparam int         N_MIN   = 20;
    localparam logic [6:0] NUM_CH_W = 7'd79;
    localparam logic [6:0] LAST_K_W = 7'd78;
    localparam logic [6:0] N_MIN_W  = 7'd20;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SCAN   = 2'd1,
        ST_FINISH = 2'd2
    } afh_state_e;

    // Basic mapping order: even channels 0..78 first, then odd channels 1..77.
    function automatic logic [6:0] basic_to_rf(input logic [6:0] k);
        logic [6:0] odd_off;
        odd_off = k - 7'd40;
        if (k <= 7'd39) begin
            basic_to_rf = {k[5:0], 1'b0};
        end else begin
            basic_to_rf = {odd_off[5:0], 1'b1};
        end
    endfunction

endpackage

// File: rtl/afh_map_ram.sv
// 79x7 remap table: async-reset register file, one registered write port, one async read port.
module afh_map_ram
    import afh_pkg::*;
(
    input  logic       clk,
    input  logic       rstz,
    input  logic       we_i,
    input  logic [6:0] waddr_i,
    input  logic [6:0] wdata_i,
    input  logic [6:0] raddr_i,
    output logic [6:0] rdata_o
);

    logic [6:0] mem_q [NUM_CH];

    // Table storage; cleared to zero on reset.
    always_ff @(posedge clk or negedge rstz) begin
        if (!rstz) begin
            for (int i = 0; i < NUM_CH; i++) begin
                mem_q[i] <= 7'd0;
            end
        end else if (we_i && (waddr_i < NUM_CH_W)) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = (raddr_i < NUM_CH_W) ? mem_q[raddr_i] : 7'd0;

endmodule

// File: rtl/afh_map_builder.sv
// Builds the AFH remap table and used-channel count N from a snapshot of the channel map.
// Define AFH_MAP_DBUF_EN for a double-buffered table that swaps banks on a successful build.
module afh_map_builder
    import afh_pkg::*;
(
    input  logic        clk,
    input  logic        rstz,
    input  logic        start,
    input  logic [79:0] channel_map,
    input  logic [6:0]  rd_idx,
    output logic [6:0]  rd_ch,
    output logic [6:0]  afh_modN,
    output logic        busy,
    output logic        done,
    output logic        map_valid,
    output logic        map_err
);

    afh_state_e  state_q;
    logic [6:0]  k_q;
    logic [6:0]  cnt_q;
    logic [6:0]  modn_q;
    logic [78:0] snap_q;
    logic        busy_q;
    logic        done_q;
    logic        valid_q;
    logic        err_q;
    logic [6:0]  scan_ch_s;
    logic        wr_en_s;

    assign scan_ch_s = basic_to_rf(k_q);
    // The abort edge (start while scanning) must not write into the table.
    assign wr_en_s   = (state_q == ST_SCAN) && !start && snap_q[scan_ch_s];

`ifdef AFH_MAP_DBUF_EN
    logic       bank_q;
    logic [6:0] rd0_s;
    logic [6:0] rd1_s;

    afh_map_ram u_ram0 (
        .clk     (clk),
        .rstz    (rstz),
        .we_i    (wr_en_s && bank_q),
        .waddr_i (cnt_q),
        .wdata_i (scan_ch_s),
        .raddr_i (rd_idx),
        .rdata_o (rd0_s)
    );

    afh_map_ram u_ram1 (
        .clk     (clk),
        .rstz    (rstz),
        .we_i    (wr_en_s && !bank_q),
        .waddr_i (cnt_q),
        .wdata_i (scan_ch_s),
        .raddr_i (rd_idx),
        .rdata_o (rd1_s)
    );

    assign rd_ch = bank_q ? rd1_s : rd0_s;
`else
    afh_map_ram u_ram (
        .clk     (clk),
        .rstz    (rstz),
        .we_i    (wr_en_s),
        .waddr_i (cnt_q),
        .wdata_i (scan_ch_s),
        .raddr_i (rd_idx),
        .rdata_o (rd_ch)
    );
`endif

    // Build FSM: snapshot, 79-cycle scan, one-cycle finish with registered status outputs.
    always_ff @(posedge clk or negedge rstz) begin
        if (!rstz) begin
            state_q <= ST_IDLE;
            k_q     <= 7'd0;
            cnt_q   <= 7'd0;
            modn_q  <= 7'd0;
            snap_q  <= 79'd0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            valid_q <= 1'b0;
            err_q   <= 1'b0;
`ifdef AFH_MAP_DBUF_EN
            bank_q  <= 1'b0;
`endif
        end else begin
            done_q <= 1'b0;
            case (state_q)
                ST_IDLE, ST_SCAN: begin
                    if (start) begin
                        snap_q  <= channel_map[78:0];
                        k_q     <= 7'd0;
                        cnt_q   <= 7'd0;
                        busy_q  <= 1'b1;
                        state_q <= ST_SCAN;
`ifndef AFH_MAP_DBUF_EN
                        valid_q <= 1'b0;
`endif
                    end else if (state_q == ST_SCAN) begin
                        if (snap_q[scan_ch_s]) begin
                            cnt_q <= cnt_q + 7'd1;
                        end
                        if (k_q == LAST_K_W) begin
                            state_q <= ST_FINISH;
                        end else begin
                            k_q <= k_q + 7'd1;
                        end
                    end
                end
                ST_FINISH: begin
                    busy_q  <= 1'b0;
                    done_q  <= 1'b1;
                    err_q   <= (cnt_q < N_MIN_W);
                    state_q <= ST_IDLE;
`ifdef AFH_MAP_DBUF_EN
                    if (cnt_q >= N_MIN_W) begin
                        modn_q  <= cnt_q;
                        valid_q <= 1'b1;
                        bank_q  <= ~bank_q;
                    end
`else
                    modn_q  <= cnt_q;
                    valid_q <= (cnt_q >= N_MIN_W);
`endif
                end
                default: begin
                    busy_q  <= 1'b0;
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign afh_modN  = modn_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign map_valid = valid_q;
    assign map_err   = err_q;

endmodule

// File: tb/tb_afh_map_builder.sv
// Randomized self-checking bench for afh_map_builder against a list-based reference model.
module tb_afh_map_builder;

    logic        clk = 1'b0;
    logic        rstz = 1'b0;
    logic        start = 1'b0;
    logic [79:0] channel_map = 80'd0;
    logic [6:0]  rd_idx = 7'd0;
    logic [6:0]  rd_ch;
    logic [6:0]  afh_modN;
    logic        busy;
    logic        done;
    logic        map_valid;
    logic        map_err;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: two table banks (only bank 0 used without double buffering).
    logic [6:0] m_tab [2][79];
    int m_act = 0;
    int m_cnt = 0;
    int m_n = 0;
    bit m_valid = 1'b0;
    bit m_err = 1'b0;

    afh_map_builder dut (
        .clk         (clk),
        .rstz        (rstz),
        .start       (start),
        .channel_map (channel_map),
        .rd_idx      (rd_idx),
        .rd_ch       (rd_ch),
        .afh_modN    (afh_modN),
        .busy        (busy),
        .done        (done),
        .map_valid   (map_valid),
        .map_err     (map_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic int target_bank();
`ifdef AFH_MAP_DBUF_EN
        return 1 - m_act;
`else
        return 0;
`endif
    endfunction

    // Walk the first `steps` entries of the basic-mapping channel order and append used channels.
    task automatic model_scan(input logic [79:0] map, input int steps);
        int order[$];
        int tb;
        for (int c = 0; c <= 78; c += 2) order.push_back(c);
        for (int c = 1; c <= 77; c += 2) order.push_back(c);
        tb = target_bank();
        m_cnt = 0;
        for (int s = 0; s < steps; s++) begin
            if (map[order[s]]) begin
                m_tab[tb][m_cnt] = 7'(order[s]);
                m_cnt++;
            end
        end
    endtask

    task automatic model_finish();
        m_err = (m_cnt < 20);
`ifdef AFH_MAP_DBUF_EN
        if (m_cnt >= 20) begin
            m_act = 1 - m_act;
            m_n = m_cnt;
            m_valid = 1'b1;
        end
`else
        m_n = m_cnt;
        m_valid = (m_cnt >= 20);
`endif
    endtask

    task automatic model_reset();
        for (int b = 0; b < 2; b++)
            for (int i = 0; i < 79; i++) m_tab[b][i] = 7'd0;
        m_act = 0;
        m_cnt = 0;
        m_n = 0;
        m_valid = 1'b0;
        m_err = 1'b0;
    endtask

    task automatic check_in_scan(input string tag);
`ifdef AFH_MAP_DBUF_EN
        check({tag, "_valid"}, 32'(map_valid), 32'(m_valid));
        check({tag, "_rdch"}, 32'(rd_ch), 32'(m_tab[m_act][40]));
`else
        check({tag, "_valid"}, 32'(map_valid), 32'd0);
`endif
        check({tag, "_modn"}, 32'(afh_modN), 32'(m_n));
    endtask

    task automatic sweep_table(input string tag);
        for (int i = 0; i < 80; i++) begin
            rd_idx = 7'(i);
            #1;
            check($sformatf("%s_rd%0d", tag, i), 32'(rd_ch), (i < 79) ? 32'(m_tab[m_act][i]) : 32'd0);
        end
        rd_idx = 7'd40;
        @(negedge clk);
    endtask

    // Called just after a negedge: pulse start so it is sampled at the next posedge (edge 0).
    task automatic kick(input logic [79:0] map);
        channel_map = map;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        channel_map = {$urandom, $urandom, $urandom};
    endtask

    task automatic run_build(input string tag, input logic [79:0] map);
        rd_idx = 7'd40;
        kick(map);
        check({tag, "_busy0"}, 32'(busy), 32'd1);
        check_in_scan({tag, "_s0"});
        model_scan(map, 79);
        for (int i = 1; i <= 80; i++) begin
            @(negedge clk);
            check($sformatf("%s_done%0d", tag, i), 32'(done), 32'(i == 80));
            check($sformatf("%s_busy%0d", tag, i), 32'(busy), 32'(i < 80));
            if (i == 60) check_in_scan({tag, "_s60"});
        end
        model_finish();
        check({tag, "_modn"}, 32'(afh_modN), 32'(m_n));
        check({tag, "_valid"}, 32'(map_valid), 32'(m_valid));
        check({tag, "_err"}, 32'(map_err), 32'(m_err));
        @(negedge clk);
        check({tag, "_done_end"}, 32'(done), 32'd0);
        sweep_table(tag);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_busy"}, 32'(busy), 32'd0);
        check({tag, "_done"}, 32'(done), 32'd0);
        check({tag, "_valid"}, 32'(map_valid), 32'd0);
        check({tag, "_err"}, 32'(map_err), 32'd0);
        check({tag, "_modn"}, 32'(afh_modN), 32'd0);
        for (int i = 0; i < 79; i += 13) begin
            rd_idx = 7'(i);
            #1;
            check($sformatf("%s_rd%0d", tag, i), 32'(rd_ch), 32'd0);
        end
    endtask

    logic [79:0] map_full, map_even20, map_lo19, map_a, map_b, map_r;

    initial begin
        map_full = '0;
        map_even20 = '0;
        map_lo19 = '0;
        for (int c = 0; c < 79; c++) map_full[c] = 1'b1;
        for (int c = 0; c <= 38; c += 2) map_even20[c] = 1'b1;
        for (int c = 0; c <= 18; c++) map_lo19[c] = 1'b1;
        map_full[79] = 1'b1;
        model_reset();

        repeat (3) @(negedge clk);
        check_all_zero("reset");
        rstz = 1'b1;
        @(negedge clk);

        run_build("full", map_full);
        run_build("even20", map_even20);
        run_build("lo19", map_lo19);
        run_build("full2", map_full);

        // Abort: restart at edge 30 with a different map; aborted writes stay in entries >= N.
        map_a = {$urandom, $urandom, $urandom} | {16'd0, 64'hFFFF_FFFF_FFFF_FFFF};
        map_b = map_even20 | 80'h1;
        rd_idx = 7'd40;
        kick(map_a);
        for (int i = 1; i <= 29; i++) begin
            @(negedge clk);
            check($sformatf("abort_done%0d", i), 32'(done), 32'd0);
        end
        model_scan(map_a, 29);
        run_build("restart", map_b);

        for (int t = 0; t < 6; t++) begin
            map_r = {$urandom, $urandom, $urandom};
            if (t % 2 == 1) map_r = map_r & {$urandom, $urandom, $urandom} & {$urandom, $urandom, $urandom};
            run_build($sformatf("rnd%0d", t), map_r);
        end

        // Reset in the middle of a scan.
        kick(map_full);
        repeat (50) @(negedge clk);
        rstz = 1'b0;
        #1;
        model_reset();
        check_all_zero("midrst");
        @(negedge clk);
        rstz = 1'b1;
        @(negedge clk);
        run_build("postrst", map_full);
        run_build("postrst20", map_even20);
        run_build("postrst19", map_lo19);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
